id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a halt drain FSM.
// Once a halt reaches EX, the stage bubbles until the core is reset.
module id_ex_stage #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic            MemRead,
   input  logic            MemtoReg,
   input  logic            MemWrite,
   input  logic            ALUSrc,
   input  logic            RegWrite,
   input  logic            Branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic            auipc,
   input  logic            halt,
   input  logic [1:0]      ALUOp,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_funct,
   input  logic            stall,
   input  logic            flush,
   output logic            ex_valid,
   output logic            ex_MemRead,
   output logic            ex_MemtoReg,
   output logic            ex_MemWrite,
   output logic            ex_ALUSrc,
   output logic            ex_RegWrite,
   output logic            ex_Branch,
   output logic            ex_jal,
   output logic            ex_jalr,
   output logic            ex_auipc,
   output logic            ex_halt,
   output logic [1:0]      ex_ALUOp,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_funct,
   output logic            load_use,
   output logic            halted
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic            valid;
      logic            memRead;
      logic            memtoReg;
      logic            memWrite;
      logic            aluSrc;
      logic            regWrite;
      logic            branch;
      logic            jal;
      logic            jalr;
      logic            auipc;
      logic            halt;
      logic [1:0]      aluOp;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1Data;
      logic [XLEN-1:0] rs2Data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      funct;
   } exReg_t;

   exReg_t         r_ex;
   exReg_t         w_idBundle;
   state_t         r_state;
   state_t         w_nextState;
   logic [CW-1:0]  r_drainCnt;
   logic [CW-1:0]  w_nextCnt;
   logic           w_load;

   assign w_idBundle = '{valid: 1'b1, memRead: MemRead, memtoReg: MemtoReg,
                         memWrite: MemWrite, aluSrc: ALUSrc, regWrite: RegWrite,
                         branch: Branch, jal: jal, jalr: jalr, auipc: auipc,
                         halt: halt, aluOp: ALUOp, pc: id_pc, rs1Data: id_rs1_data,
                         rs2Data: id_rs2_data, imm: id_imm, rs1: id_rs1,
                         rs2: id_rs2, rd: id_rd, funct: id_funct};

   assign load_use = id_valid & r_ex.valid & r_ex.memRead & (r_ex.rd != 5'd0) &
                     ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2));

   // Anything that is not a clean load becomes a bubble, so X on ID never reaches EX.
   assign w_load = id_valid & ~load_use & (r_state == RUN) & ~stall & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ex <= '0;
      else if (flush)
         r_ex <= '0;
      else if (stall)
         r_ex <= r_ex;
      else if (w_load)
         r_ex <= w_idBundle;
      else
         r_ex <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_drainCnt <= '0;
      end else begin
         r_state    <= w_nextState;
         r_drainCnt <= w_nextCnt;
      end
   end

   // The drain ignores stall and flush: the halt is already committed once in EX.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_drainCnt;
      case (r_state)
         RUN: begin
            if (w_load && halt) begin
               w_nextState = DRAIN;
               w_nextCnt   = CW'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            if (r_drainCnt <= CW'(1)) begin
               w_nextState = HALTED;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_drainCnt - CW'(1);
            end
         end
         HALTED: w_nextState = HALTED;
         default: w_nextState = RUN;
      endcase
   end

   assign halted      = (r_state == HALTED);
   assign ex_valid    = r_ex.valid;
   assign ex_MemRead  = r_ex.memRead;
   assign ex_MemtoReg = r_ex.memtoReg;
   assign ex_MemWrite = r_ex.memWrite;
   assign ex_ALUSrc   = r_ex.aluSrc;
   assign ex_RegWrite = r_ex.regWrite;
   assign ex_Branch   = r_ex.branch;
   assign ex_jal      = r_ex.jal;
   assign ex_jalr     = r_ex.jalr;
   assign ex_auipc    = r_ex.auipc;
   assign ex_halt     = r_ex.halt;
   assign ex_ALUOp    = r_ex.aluOp;
   assign ex_pc       = r_ex.pc;
   assign ex_rs1_data = r_ex.rs1Data;
   assign ex_rs2_data = r_ex.rs2Data;
   assign ex_imm      = r_ex.imm;
   assign ex_rs1      = r_ex.rs1;
   assign ex_rs2      = r_ex.rs2;
   assign ex_rd       = r_ex.rd;
   assign ex_funct    = r_ex.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage: expected EX contents are queued as
// stimulus is applied and compared one cycle later.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [9:0]  ctl;   // {MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,Branch,jal,jalr,auipc,halt}
      logic [1:0]  aluOp;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
   } exVec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Branch, jal, jalr, auipc, halt;
   logic [1:0] ALUOp;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [3:0] id_funct;
   logic stall, flush;
   logic ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Branch;
   logic ex_jal, ex_jalr, ex_auipc, ex_halt;
   logic [1:0] ex_ALUOp;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [3:0] ex_funct;
   logic load_use, halted;

   int total = 0;
   int bad   = 0;
   exVec_t sbQ[$];
   exVec_t kZero = '0;

   id_ex_stage #(.XLEN(32), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
      .RegWrite(RegWrite), .Branch(Branch), .jal(jal), .jalr(jalr), .auipc(auipc),
      .halt(halt), .ALUOp(ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_funct(id_funct), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
      .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
      .ex_Branch(ex_Branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_auipc(ex_auipc),
      .ex_halt(ex_halt), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_funct(ex_funct), .load_use(load_use), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exVec_t getObs();
      exVec_t v;
      v = {ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Branch,
           ex_jal, ex_jalr, ex_auipc, ex_halt, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};
      return v;
   endfunction

   function automatic exVec_t randInstr();
      exVec_t v;
      v.valid  = 1'b1;
      v.ctl    = 10'($urandom);
      v.ctl[9] = 1'b0;
      v.ctl[0] = 1'b0;
      v.aluOp  = 2'($urandom);
      v.pc     = $urandom;
      v.rs1d   = $urandom;
      v.rs2d   = $urandom;
      v.imm    = $urandom;
      v.rs1    = 5'($urandom);
      v.rs2    = 5'($urandom);
      v.rd     = 5'($urandom);
      v.funct  = 4'($urandom);
      return v;
   endfunction

   task automatic applyStimulus(input exVec_t v);
      id_valid = v.valid;
      {MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Branch, jal, jalr, auipc, halt} = v.ctl;
      ALUOp = v.aluOp;
      id_pc = v.pc;
      id_rs1_data = v.rs1d;
      id_rs2_data = v.rs2d;
      id_imm = v.imm;
      id_rs1 = v.rs1;
      id_rs2 = v.rs2;
      id_rd = v.rd;
      id_funct = v.funct;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exVec_t obs;
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      applyStimulus(kZero);
      repeat (2) tick();
      obs = getObs();
      total++;
      if (obs !== kZero) begin
         bad++;
         $display("FAIL reset_ex got=%h want=%h", obs, kZero);
      end
      total++;
      if (halted !== 1'b0 || load_use !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got halted=%b load_use=%b want 0/0", halted, load_use);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      exVec_t v, obs, exp;
      v = randInstr();
      v.ctl = 10'b0000100000;
      v.aluOp = 2'b10;
      v.rd = 5'd5;
      v.rs1d = 32'h11;
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL load_basic got=%h want=%h", obs, exp);
      end
      for (int i = 0; i < 4; i++) begin
         v = randInstr();
         applyStimulus(v);
         sbQ.push_back(v);
         tick();
         exp = sbQ.pop_front();
         obs = getObs();
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL load_b2b[%0d] got=%h want=%h", i, obs, exp);
         end
      end
   endtask

   task automatic test_load_use();
      exVec_t v, obs, exp;
      v = randInstr();
      v.ctl[9] = 1'b1;
      v.rd = 5'd7;
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lu_producer got=%h want=%h", obs, exp);
      end
      v = randInstr();
      v.rs1 = 5'd3;
      v.rs2 = 5'd7;
      applyStimulus(v);
      #1;
      total++;
      if (load_use !== 1'b1) begin
         bad++;
         $display("FAIL lu_detect got=%b want=1", load_use);
      end
      sbQ.push_back(kZero);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lu_bubble got=%h want=%h", obs, exp);
      end
      v = randInstr();
      v.ctl[9] = 1'b1;
      v.rd = 5'd0;
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lu_x0_producer got=%h want=%h", obs, exp);
      end
      v = randInstr();
      v.rs1 = 5'd0;
      v.rs2 = 5'd0;
      applyStimulus(v);
      #1;
      total++;
      if (load_use !== 1'b0) begin
         bad++;
         $display("FAIL lu_x0_detect got=%b want=0", load_use);
      end
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lu_x0_load got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_priority();
      exVec_t v, held, obs, exp;
      v = randInstr();
      v.ctl[5] = 1'b1;
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      void'(sbQ.pop_front());
      v = randInstr();
      applyStimulus(v);
      stall = 1'b1;
      flush = 1'b1;
      sbQ.push_back(kZero);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL flush_over_stall got=%h want=%h", obs, exp);
      end
      stall = 1'b0;
      flush = 1'b0;
      held = randInstr();
      applyStimulus(held);
      sbQ.push_back(held);
      tick();
      void'(sbQ.pop_front());
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(randInstr());
         sbQ.push_back(held);
         tick();
         exp = sbQ.pop_front();
         obs = getObs();
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs, exp);
         end
      end
      stall = 1'b0;
      id_valid = 1'b0;
      {MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Branch, jal, jalr, auipc, halt} = 'x;
      ALUOp = 'x;
      id_pc = 'x;
      id_rs1_data = 'x;
      id_rs2_data = 'x;
      id_imm = 'x;
      id_rs1 = 'x;
      id_rs2 = 'x;
      id_rd = 'x;
      id_funct = 'x;
      sbQ.push_back(kZero);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL bubble_x got=%h want=%h", obs, exp);
      end
      applyStimulus(kZero);
   endtask

   task automatic test_halt_kill();
      exVec_t v, obs, exp;
      v = randInstr();
      v.ctl[0] = 1'b1;
      applyStimulus(v);
      flush = 1'b1;
      sbQ.push_back(kZero);
      tick();
      flush = 1'b0;
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL halt_kill_ex got=%h want=%h", obs, exp);
      end
      applyStimulus(kZero);
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_kill_halted[%0d] got=%b want=0", i, halted);
         end
      end
      v = randInstr();
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL halt_kill_run got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_halt();
      exVec_t v, obs, exp;
      logic expHalted;
      v = randInstr();
      v.ctl[0] = 1'b1;
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp || halted !== 1'b0) begin
         bad++;
         $display("FAIL halt_capture got=%h halted=%b want=%h halted=0", obs, halted, exp);
      end
      for (int i = 2; i <= 5; i++) begin
         applyStimulus(randInstr());
         flush = (i == 2);
         expHalted = (i >= 3);
         sbQ.push_back(kZero);
         tick();
         exp = sbQ.pop_front();
         obs = getObs();
         total++;
         if (obs !== exp || halted !== expHalted) begin
            bad++;
            $display("FAIL halt_edge%0d got=%h halted=%b want=%h halted=%b",
                     i, obs, halted, exp, expHalted);
         end
      end
      flush = 1'b0;
   endtask

   task automatic test_async_reset();
      exVec_t v, obs, exp;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (halted !== 1'b0 || ex_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got halted=%b ex_valid=%b want 0/0", halted, ex_valid);
      end
      #2 rst_n = 1'b1;
      v = randInstr();
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL post_reset_load got=%h want=%h", obs, exp);
      end
      v = randInstr();
      v.ctl[0] = 1'b1;
      applyStimulus(v);
      tick();
      applyStimulus(kZero);
      tick();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      v = randInstr();
      applyStimulus(v);
      sbQ.push_back(v);
      tick();
      exp = sbQ.pop_front();
      obs = getObs();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL drain_reset_load got=%h want=%h", obs, exp);
      end
      applyStimulus(kZero);
      repeat (4) tick();
      total++;
      if (halted !== 1'b0) begin
         bad++;
         $display("FAIL drain_reset_halted got=%b want=0", halted);
      end
   endtask

   initial begin
      $display("[TB] starting id_ex_stage bench");
      test_reset();
      test_load();
      test_load_use();
      test_priority();
      test_halt_kill();
      test_halt();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
